// File: rtl/score_arb_pkg.sv
// Shared definitions for the score event arbiter.
// - arb_state_e : arbiter FSM states (IDLE, ISSUE, SETTLE)
// - player_e    : round-robin pointer values
// - PLUS1/PLUS2/MINUS2 : bit positions of the events inside a req/pending vector
// - SETTLE_CYCLES_DEF  : default idle gap after each issued command
// - pick_event()       : fixed-priority event selector (minus2 > plus2 > plus1)
package score_arb_pkg;

    localparam int SETTLE_CYCLES_DEF = 1;
    localparam int EVT_W  = 3;
    localparam int PLUS1  = 0;
    localparam int PLUS2  = 1;
    localparam int MINUS2 = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2
    } arb_state_e;

    typedef enum logic {
        PLAYER1 = 1'b0,
        PLAYER2 = 1'b1
    } player_e;

    // One-hot of the highest-priority pending event, zero if nothing pending.
    function automatic logic [EVT_W-1:0] pick_event(input logic [EVT_W-1:0] pend);
        logic [EVT_W-1:0] sel;
        sel = '0;
        if (pend[MINUS2]) begin
            sel[MINUS2] = 1'b1;
        end else if (pend[PLUS2]) begin
            sel[PLUS2] = 1'b1;
        end else if (pend[PLUS1]) begin
            sel[PLUS1] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/score_event_arbiter_if.sv
// Signal bundle between the score event sources and the arbiter.
// - p1_req/p2_req : per-player event requests {minus2, plus2, plus1}
// - freeze        : game over, blocks new grants
// - p1_*/p2_*     : single-cycle commands to each player's digit chain
// - busy          : arbiter is issuing or settling
// - dropped       : an event was lost because it was already pending
// Modports: master drives requests/freeze, slave (the arbiter) drives commands.
interface score_event_arbiter_if;

    logic [2:0] p1_req;
    logic [2:0] p2_req;
    logic       freeze;
    logic       p1_plus1;
    logic       p1_plus2;
    logic       p1_minus2;
    logic       p2_plus1;
    logic       p2_plus2;
    logic       p2_minus2;
    logic       busy;
    logic       dropped;

    modport master (
        output p1_req, p2_req, freeze,
        input  p1_plus1, p1_plus2, p1_minus2,
        input  p2_plus1, p2_plus2, p2_minus2,
        input  busy, dropped
    );

    modport slave (
        input  p1_req, p2_req, freeze,
        output p1_plus1, p1_plus2, p1_minus2,
        output p2_plus1, p2_plus2, p2_minus2,
        output busy, dropped
    );

endinterface

// File: rtl/score_event_capture.sv
// Per-player event capture: rising-edge detection on the request lines,
// pending-event flags, and a one-cycle pulse when an event hits a flag
// that is already set.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i        : raw request bits {minus2, plus2, plus1}
//   clr_i        : clear strobes from the arbiter for granted events
//   pending_o    : pending event flags
//   dropped_o    : registered pulse, one cycle per lost event
module score_event_capture
    import score_arb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [EVT_W-1:0] req_i,
    input  logic [EVT_W-1:0] clr_i,
    output logic [EVT_W-1:0] pending_o,
    output logic             dropped_o
);

    logic [EVT_W-1:0] req_q;
    logic [EVT_W-1:0] prev_q;
    logic [EVT_W-1:0] pend_q;
    logic [EVT_W-1:0] pend_d;
    logic [EVT_W-1:0] rise;
    logic             drop_q;
    logic             drop_d;

    // req_q/prev_q reset to ones so a request held high through reset
    // release never looks like a fresh edge.
    assign rise   = req_q & ~prev_q;
    // A set in the same cycle as a clear wins, and is not a drop.
    assign pend_d = (pend_q & ~clr_i) | rise;
    assign drop_d = |(rise & pend_q & ~clr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q  <= '1;
            prev_q <= '1;
            pend_q <= '0;
            drop_q <= 1'b0;
        end else begin
            req_q  <= req_i;
            prev_q <= req_q;
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    assign pending_o = pend_q;
    assign dropped_o = drop_q;

endmodule

// File: rtl/score_event_arbiter.sv
// Score event arbiter: collects plus1/plus2/minus2 events from two players
// and serialises them into single-cycle commands for the digit chains,
// with a settle gap of SETTLE_CYCLES cycles after every command.
// Ports:
//   Clock  : single clock, rising edge
//   Reset  : asynchronous active-high reset
//   bus_if : slave side of score_event_arbiter_if (requests, freeze,
//            six command outputs, busy, dropped)
// Player selection is round-robin, event selection is fixed priority
// minus2 > plus2 > plus1. The command register is loaded on entry to
// ISSUE, so the command is high exactly while the FSM is in ISSUE.
module score_event_arbiter
    import score_arb_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    score_event_arbiter_if.slave  bus_if
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    arb_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    player_e          rr_q, rr_d;
    logic [5:0]       cmd_q, cmd_d;

    logic [EVT_W-1:0] pend1, pend2;
    logic [EVT_W-1:0] clr1, clr2;
    logic [EVT_W-1:0] evt_sel;
    logic             drop1, drop2;
    logic             sel_p2;
    logic             grant_ok;
    logic             start;

    score_event_capture u_cap_p1 (
        .clk_i     (Clock),
        .rst_i     (Reset),
        .req_i     (bus_if.p1_req),
        .clr_i     (clr1),
        .pending_o (pend1),
        .dropped_o (drop1)
    );

    score_event_capture u_cap_p2 (
        .clk_i     (Clock),
        .rst_i     (Reset),
        .req_i     (bus_if.p2_req),
        .clr_i     (clr2),
        .pending_o (pend2),
        .dropped_o (drop2)
    );

    // rr_q names the preferred player; fall back to the other one when the
    // preferred player has nothing pending.
    assign sel_p2   = (rr_q == PLAYER2) ? (|pend2) : ~(|pend1);
    assign evt_sel  = pick_event(sel_p2 ? pend2 : pend1);
    assign grant_ok = ~bus_if.freeze & ((|pend1) | (|pend2));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        cmd_d   = '0;
        clr1    = '0;
        clr2    = '0;
        start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    start = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_SETTLE;
                cnt_d   = 4'd1;
            end
            ST_SETTLE: begin
                // The last settle cycle hands straight over to the next
                // ISSUE when work is waiting, so back-to-back commands are
                // spaced exactly 1 + SETTLE_CYCLES apart.
                if (cnt_q >= SETTLE_LAST) begin
                    if (grant_ok) begin
                        start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start) begin
            state_d = ST_ISSUE;
            cnt_d   = '0;
            rr_d    = sel_p2 ? PLAYER1 : PLAYER2;
            if (sel_p2) begin
                cmd_d = {evt_sel, 3'b000};
                clr2  = evt_sel;
            end else begin
                cmd_d = {3'b000, evt_sel};
                clr1  = evt_sel;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rr_q    <= PLAYER1;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            cmd_q   <= cmd_d;
        end
    end

    assign bus_if.p1_plus1  = cmd_q[PLUS1];
    assign bus_if.p1_plus2  = cmd_q[PLUS2];
    assign bus_if.p1_minus2 = cmd_q[MINUS2];
    assign bus_if.p2_plus1  = cmd_q[3 + PLUS1];
    assign bus_if.p2_plus2  = cmd_q[3 + PLUS2];
    assign bus_if.p2_minus2 = cmd_q[3 + MINUS2];
    assign bus_if.busy      = (state_q != ST_IDLE);
    assign bus_if.dropped   = drop1 | drop2;

endmodule

// File: tb/tb_score_event_arbiter.sv
// Scoreboard bench for score_event_arbiter (SETTLE_CYCLES = 3).
// Stimulus pushes {command, cycle} expectations; a negedge monitor pops one
// entry per observed command and checks both the command and its timing.
module tb_score_event_arbiter;

    localparam int S = 3;

    localparam logic [5:0] C_P1P1 = 6'b000001;
    localparam logic [5:0] C_P1P2 = 6'b000010;
    localparam logic [5:0] C_P1M2 = 6'b000100;
    localparam logic [5:0] C_P2P1 = 6'b001000;
    localparam logic [5:0] C_P2P2 = 6'b010000;
    localparam logic [5:0] C_P2M2 = 6'b100000;

    typedef struct {
        logic [5:0] cmd;
        int         cyc;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    score_event_arbiter_if bus();

    score_event_arbiter #(.SETTLE_CYCLES(S)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .bus_if (bus)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [5:0] cmd_vec();
        return {bus.p2_minus2, bus.p2_plus2, bus.p2_plus1,
                bus.p1_minus2, bus.p1_plus2, bus.p1_plus1};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [5:0] c, input int at);
        exp_t e;
        e.cmd = c;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    // Monitor: every non-zero command vector must be one-hot and match the
    // next scoreboard entry, on the expected cycle.
    always @(negedge Clock) begin
        logic [5:0] c;
        exp_t       e;
        c = cmd_vec();
        if (!Reset && c != 6'b0) begin
            chk("onehot", $countones(c), 1);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_cmd: got %b at cycle %0d, none expected", c, cyc);
            end else begin
                e = exp_q.pop_front();
                if (c !== e.cmd || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL cmd: got %b at cycle %0d expected %b at cycle %0d",
                             c, cyc, e.cmd, e.cyc);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge Clock);
        Reset      = 1'b1;
        bus.p1_req = 3'b000;
        bus.p2_req = 3'b000;
        bus.freeze = 1'b0;
        repeat (2) @(negedge Clock);
        chk("rst_cmd", int'(cmd_vec()), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_dropped", int'(bus.dropped), 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
    endtask

    initial begin
        int c;
        bus.p1_req = 3'b000;
        bus.p2_req = 3'b000;
        bus.freeze = 1'b0;
        do_reset();

        // Single event plus busy window
        c = cyc;
        bus.p1_req = 3'b001;
        push(C_P1P1, c + 3);
        @(negedge Clock);
        bus.p1_req = 3'b000;
        for (int i = 2; i <= 8; i++) begin
            @(negedge Clock);
            chk("t1_busy", int'(bus.busy), int'(i >= 3 && i <= 3 + S));
        end
        repeat (4) @(negedge Clock);

        // Round robin: last grant was player 1, so player 2 goes first
        c = cyc;
        bus.p1_req = 3'b001;
        bus.p2_req = 3'b001;
        push(C_P2P1, c + 3);
        push(C_P1P1, c + 3 + (1 + S));
        @(negedge Clock);
        bus.p1_req = 3'b000;
        bus.p2_req = 3'b000;
        repeat (12) @(negedge Clock);

        // Simultaneous players after reset
        do_reset();
        c = cyc;
        bus.p1_req = 3'b010;
        bus.p2_req = 3'b100;
        push(C_P1P2, c + 3);
        push(C_P2M2, c + 3 + (1 + S));
        @(negedge Clock);
        bus.p1_req = 3'b000;
        bus.p2_req = 3'b000;
        repeat (12) @(negedge Clock);

        // Intra-player priority, back-to-back spacing 1 + S
        c = cyc;
        bus.p1_req = 3'b111;
        push(C_P1M2, c + 3);
        push(C_P1P2, c + 3 + (1 + S));
        push(C_P1P1, c + 3 + 2 * (1 + S));
        @(negedge Clock);
        bus.p1_req = 3'b000;
        repeat (16) @(negedge Clock);

        // Drop while frozen, single grant after thaw
        c = cyc;
        bus.freeze = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clock);
            chk("t4_dropped", int'(bus.dropped), int'(i == 5));
            chk("t4_busy", int'(bus.busy), 0);
            bus.p2_req = (i == 1 || i == 3) ? 3'b001 : 3'b000;
        end
        bus.freeze = 1'b0;
        push(C_P2P1, cyc + 1);
        repeat (8) @(negedge Clock);

        // Freeze raised during SETTLE: finish the period, then hold
        c = cyc;
        bus.p1_req = 3'b011;
        push(C_P1P2, c + 3);
        @(negedge Clock);
        bus.p1_req = 3'b000;
        repeat (3) @(negedge Clock);
        bus.freeze = 1'b1;
        repeat (2) @(negedge Clock);
        chk("t5_busy_settle", int'(bus.busy), 1);
        @(negedge Clock);
        chk("t5_busy_frozen", int'(bus.busy), 0);
        repeat (3) @(negedge Clock);
        bus.freeze = 1'b0;
        push(C_P1P1, cyc + 1);
        repeat (8) @(negedge Clock);

        // Reset mid-ISSUE with p1 request held through release
        do_reset();
        c = cyc;
        bus.p1_req = 3'b001;
        bus.p2_req = 3'b100;
        push(C_P1P1, c + 3);
        @(negedge Clock);
        bus.p2_req = 3'b000;
        repeat (2) @(negedge Clock);
        #1;
        Reset = 1'b1;
        #1;
        chk("t6_cmd_in_reset", int'(cmd_vec()), 0);
        chk("t6_busy_in_reset", int'(bus.busy), 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (12) @(negedge Clock);
        chk("t6_busy_after", int'(bus.busy), 0);
        bus.p1_req = 3'b000;
        repeat (4) @(negedge Clock);

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/score_event_arbiter.md
SCORE_EVENT_ARBITER -- requirements
Module: score_event_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of idle cycles after each issued command (range 1..15).
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port p1_req, input, 3 bits: player-1 event requests, synchronous to Clock; bit0 = plus1, bit1 = plus2, bit2 = minus2.
REQ-005 SHALL have port p2_req, input, 3 bits: player-2 event requests, same encoding as p1_req.
REQ-006 SHALL have port freeze, input, 1 bit: game over; blocks new grants while high.
REQ-007 SHALL have ports p1_plus1, p1_plus2 and p1_minus2, outputs, 1 bit each: single-cycle commands to the player-1 digit chain.
REQ-008 SHALL have ports p2_plus1, p2_plus2 and p2_minus2, outputs, 1 bit each: single-cycle commands to the player-2 digit chain.
REQ-009 SHALL have port busy, output, 1 bit: high in the ISSUE and SETTLE states.
REQ-010 SHALL have port dropped, output, 1 bit: one-cycle pulse when an event is lost because the same event is already pending.

Function
REQ-011 SHALL detect events on rising edges only: an event is detected when a req bit is 1 now and was 0 on the previous clock; each edge sets that player's pending bit for that event.
REQ-012 SHALL, on an edge for a bit that is already pending and is not being cleared in the same cycle, keep the pending bit at 1 and drive dropped = 1 for exactly one cycle.
REQ-013 SHALL let the set win when an edge and a clear of the same pending bit occur in the same cycle; the event stays pending and dropped stays 0.
REQ-014 SHALL implement a three-state FSM: IDLE, ISSUE and SETTLE.
REQ-015 SHALL move IDLE -> ISSUE when freeze = 0 and any pending bit is set; otherwise it stays in IDLE.
REQ-016 SHALL select the player for each grant round-robin: use the player opposite the last grant if that player has pending events, else the other player; the pointer is player 1 after reset.
REQ-017 SHALL select, within the chosen player, the event by priority minus2 > plus2 > plus1.
REQ-018 SHALL, in ISSUE (exactly 1 cycle), assert the one registered command output for the selected player and event, clear that pending bit, then go to SETTLE.
REQ-019 SHALL hold SETTLE for SETTLE_CYCLES cycles with all command outputs at 0, then return to IDLE.
REQ-020 SHALL never assert more than one of the six command outputs in any cycle.
REQ-021 SHALL give latency as follows: for an edge sampled at clock edge k with the FSM idle, the command is high from edge k+2 to edge k+3.
REQ-022 SHALL, when freeze rises during ISSUE or SETTLE, complete the current command and settle period, then stay in IDLE.
REQ-023 SHALL keep capturing edges and holding pending bits while freeze = 1, and resume granting when freeze returns to 0.
REQ-024 SHALL run the SETTLE counter at 4 bits and never let it wrap.

Reset
REQ-025 SHALL, while Reset = 1, immediately force all command outputs, busy and dropped to 0, the FSM to IDLE, pending bits to 0, the settle counter to 0 and the round-robin pointer to player 1.
REQ-026 SHALL reset the previous-req registers to all ones, so that a req held high across reset release produces no event.
REQ-027 SHALL, on reset asserted mid-ISSUE, remove the command pulse within the same cycle and lose all pending events.

Structure
REQ-028 SHALL define the FSM state enum, the event bit indices (PLUS1 = 0, PLUS2 = 1, MINUS2 = 2) and the SETTLE_CYCLES default in the shared package score_arb_pkg.
REQ-029 SHALL place edge detection and the pending/dropped logic in one sub-module, score_event_capture, instantiated once per player.

Verification
REQ-030 SHALL cover single event: p1_req = 001 for one cycle -> p1_plus1 = 1 for one cycle, 2 cycles after sampling; busy high for 1 + SETTLE_CYCLES cycles.
REQ-031 SHALL cover simultaneous players: p1_req = 010 and p2_req = 100 on the same edge -> p1_plus2 first, then p2_minus2 exactly 1 + SETTLE_CYCLES cycles later.
REQ-032 SHALL cover intra-player priority: p1_req = 111 on one edge -> commands issued in the order p1_minus2, p1_plus2, p1_plus1, with no overlap.
REQ-033 SHALL cover drop: p2_req bit0 toggles 0-1-0-1 while freeze = 1 -> dropped pulses once; after freeze falls, exactly one p2_plus1.
REQ-034 SHALL cover reset: Reset during ISSUE -> p1/p2 outputs drop to 0 the same cycle; with req held at 001 through release -> no command issued.
REQ-035 SHALL cover settle length: SETTLE_CYCLES = 3 with back-to-back pending events -> consecutive command pulses exactly 4 cycles apart.
